ov7670_config_sequencer: RTL and testbench

- Walks the OV7670 register-init ROM from address 0 and issues one SCCB register write per ROM word.
- Honours the two in-band markers: 16'hFFF0 means delay, 16'hFFFF means end of table.
- Sits between the config ROM and the SCCB master in the camera front end.
- Raises config_done so the capture path can begin accepting frames.

---
 rtl/ov7670_config_sequencer.sv | 171 +++++++++++++++++
 tb/tb_ov7670_config_sequencer.sv | 422 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ov7670_config_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | ov7670_config_sequencer                                                  |
// | Walks the OV7670 init ROM and issues one SCCB register write per word.   |
// | Rev 1.0 - initial release                                                |
// +--------------------------------------------------------------------------+
module ov7670_config_sequencer #(
    parameter int DELAY_CYCLES = 1_000_000,
    parameter int MAX_RETRIES  = 3,
    parameter bit AUTO_START   = 1'b1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    output logic [7:0]  rom_addr,
    input  logic [15:0] rom_data,
    input  logic        sccb_ready,
    output logic        sccb_start,
    output logic [7:0]  sccb_reg,
    output logic [7:0]  sccb_data,
    input  logic        sccb_done,
    input  logic        sccb_nack,
    output logic        busy,
    output logic        config_done,
    output logic        config_error,
    output logic [7:0]  write_count
);
    localparam int c_RW = (MAX_RETRIES < 1) ? 1 : $clog2(MAX_RETRIES + 1);
    localparam int c_DW = (DELAY_CYCLES < 2) ? 1 : $clog2(DELAY_CYCLES + 1);
    localparam logic [c_RW-1:0] c_RETRY_MAX  = c_RW'(MAX_RETRIES);
    localparam logic [c_DW-1:0] c_DELAY_LOAD = c_DW'(DELAY_CYCLES - 1);
    localparam logic [15:0]     c_MARK_END   = 16'hFFFF;
    localparam logic [15:0]     c_MARK_DELAY = 16'hFFF0;

    typedef enum logic [3:0] {
        S_IDLE    = 4'd0,
        S_FETCH   = 4'd1,
        S_DECODE  = 4'd2,
        S_ISSUE   = 4'd3,
        S_WAIT    = 4'd4,
        S_DELAY   = 4'd5,
        S_ADVANCE = 4'd6,
        S_DONE    = 4'd7,
        S_ERROR   = 4'd8
    } state_t;

    state_t          r_state, w_state_nxt;
    logic [7:0]      r_rom_addr, w_rom_addr_nxt;
    logic [7:0]      r_reg, w_reg_nxt;
    logic [7:0]      r_data, w_data_nxt;
    logic [7:0]      r_wcount, w_wcount_nxt;
    logic [c_RW-1:0] r_retry, w_retry_nxt, w_retry_inc;
    logic [c_DW-1:0] r_delay, w_delay_nxt;
    logic            r_fetch, w_fetch_nxt;
    logic            r_auto;
    logic            w_sccb_start;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state    <= S_IDLE;
            r_rom_addr <= '0;
            r_reg      <= '0;
            r_data     <= '0;
            r_wcount   <= '0;
            r_retry    <= '0;
            r_delay    <= '0;
            r_fetch    <= 1'b0;
            r_auto     <= AUTO_START;
        end else begin
            r_state    <= w_state_nxt;
            r_rom_addr <= w_rom_addr_nxt;
            r_reg      <= w_reg_nxt;
            r_data     <= w_data_nxt;
            r_wcount   <= w_wcount_nxt;
            r_retry    <= w_retry_nxt;
            r_delay    <= w_delay_nxt;
            r_fetch    <= w_fetch_nxt;
            r_auto     <= 1'b0;
        end
    end

    assign w_retry_inc = r_retry + c_RW'(1);

    always_comb begin
        w_state_nxt    = r_state;
        w_rom_addr_nxt = r_rom_addr;
        w_reg_nxt      = r_reg;
        w_data_nxt     = r_data;
        w_wcount_nxt   = r_wcount;
        w_retry_nxt    = r_retry;
        w_delay_nxt    = r_delay;
        w_fetch_nxt    = r_fetch;
        w_sccb_start   = 1'b0;
        case (r_state)
            // r_auto can only be set while sitting in IDLE right after reset
            S_IDLE, S_DONE, S_ERROR: begin
                if (start || r_auto) begin
                    w_rom_addr_nxt = '0;
                    w_wcount_nxt   = '0;
                    w_fetch_nxt    = 1'b0;
                    w_state_nxt    = S_FETCH;
                end
            end
            S_FETCH: begin
                if (r_fetch) begin
                    w_state_nxt = S_DECODE;
                end else begin
                    w_fetch_nxt = 1'b1;
                end
            end
            S_DECODE: begin
                if (rom_data == c_MARK_END) begin
                    w_state_nxt = S_DONE;
                end else if (rom_data == c_MARK_DELAY) begin
                    w_delay_nxt = c_DELAY_LOAD;
                    w_state_nxt = S_DELAY;
                end else begin
                    w_reg_nxt   = rom_data[15:8];
                    w_data_nxt  = rom_data[7:0];
                    w_retry_nxt = '0;
                    w_state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (sccb_ready) begin
                    w_sccb_start = 1'b1;
                    w_state_nxt  = S_WAIT;
                end
            end
            S_WAIT: begin
                if (sccb_done) begin
                    if (!sccb_nack) begin
                        w_wcount_nxt = (r_wcount == 8'hFF) ? 8'hFF : r_wcount + 8'd1;
                        w_state_nxt  = S_ADVANCE;
                    end else begin
                        w_retry_nxt = w_retry_inc;
                        w_state_nxt = (w_retry_inc == c_RETRY_MAX) ? S_ERROR : S_ISSUE;
                    end
                end
            end
            S_DELAY: begin
                if (r_delay == '0) begin
                    w_state_nxt = S_ADVANCE;
                end else begin
                    w_delay_nxt = r_delay - c_DW'(1);
                end
            end
            S_ADVANCE: begin
                if (r_rom_addr == 8'hFF) begin
                    w_state_nxt = S_DONE;
                end else begin
                    w_rom_addr_nxt = r_rom_addr + 8'd1;
                    w_fetch_nxt    = 1'b0;
                    w_state_nxt    = S_FETCH;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign rom_addr     = r_rom_addr;
    assign sccb_start   = w_sccb_start;
    assign sccb_reg     = r_reg;
    assign sccb_data    = r_data;
    assign write_count  = r_wcount;
    assign config_done  = (r_state == S_DONE);
    assign config_error = (r_state == S_ERROR);
    assign busy         = !((r_state == S_IDLE) || (r_state == S_DONE) || (r_state == S_ERROR));

endmodule
`default_nettype wire

// File: tb/tb_ov7670_config_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_ov7670_config_sequencer                                               |
// | Randomised bench with ROM/SCCB models and a table-walk reference model.  |
// | Rev 1.0 - initial release                                                |
// +--------------------------------------------------------------------------+
module tb_ov7670_config_sequencer;
    localparam int DLY  = 16;
    localparam int MAXR = 3;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  rom_addr;
    logic [15:0] rom_data;
    logic        sccb_ready = 1'b0;
    logic        sccb_start;
    logic [7:0]  sccb_reg, sccb_data;
    logic        sccb_done = 1'b0;
    logic        sccb_nack = 1'b0;
    logic        busy, config_done, config_error;
    logic [7:0]  write_count;

    ov7670_config_sequencer #(
        .DELAY_CYCLES(DLY), .MAX_RETRIES(MAXR), .AUTO_START(1'b1)
    ) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .rom_addr(rom_addr),
        .rom_data(rom_data), .sccb_ready(sccb_ready), .sccb_start(sccb_start),
        .sccb_reg(sccb_reg), .sccb_data(sccb_data), .sccb_done(sccb_done),
        .sccb_nack(sccb_nack), .busy(busy), .config_done(config_done),
        .config_error(config_error), .write_count(write_count)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    // registered ROM
    logic [15:0] rom [256];
    always @(posedge clk) rom_data <= rom[rom_addr];

    // SCCB master model
    int          cyc = 0;
    bit          pend = 0;
    int          cnt = 0;
    int          lat = 20;
    bit          ready_block = 0;
    bit          nack_all = 0;
    bit          nack_plan[$];
    logic [15:0] log_q[$];
    int          log_t[$];
    int          done_t[$];
    int          stab_bad = 0;
    int          consec_bad = 0;
    bit          prev_start = 0;
    bit          chk_hold = 0;
    logic [7:0]  hold_r, hold_d;

    always begin
        @(negedge clk);
        cyc++;
        sccb_done = 1'b0;
        sccb_nack = 1'b0;
        if (reset_n !== 1'b1) chk_hold = 0;
        if (pend) begin
            if (chk_hold && (sccb_reg !== hold_r || sccb_data !== hold_d)) stab_bad++;
            if (cnt == 0) begin
                sccb_done = 1'b1;
                sccb_nack = nack_all ? 1'b1 : (nack_plan.size() > 0 ? nack_plan.pop_front() : 1'b0);
                pend = 0;
                done_t.push_back(cyc);
            end else begin
                cnt--;
            end
        end
        sccb_ready = !pend && !ready_block;
        #1;
        if (sccb_start === 1'b1) begin
            if (prev_start) consec_bad++;
            log_q.push_back({sccb_reg, sccb_data});
            log_t.push_back(cyc);
            pend = 1;
            cnt = lat - 1;
            hold_r = sccb_reg;
            hold_d = sccb_data;
            chk_hold = 1;
        end
        prev_start = (sccb_start === 1'b1);
    end

    // reference: walk the table with the same NACK decisions the SCCB model will make
    bit          ref_plan[$];
    logic [15:0] exp_q[$];
    logic [7:0]  exp_wc, exp_addr;
    bit          exp_done, exp_err;

    task automatic ref_model();
        bit np[$];
        int wc, tries;
        bit ok, nk;
        np = ref_plan;
        exp_q.delete();
        exp_done = 0; exp_err = 0; wc = 0; exp_addr = 0;
        for (int a = 0; a < 256; a++) begin
            exp_addr = 8'(a);
            if (rom[a] == 16'hFFFF) begin exp_done = 1; break; end
            if (rom[a] == 16'hFFF0) begin
                if (a == 255) exp_done = 1;
                continue;
            end
            ok = 0; tries = 0;
            while (!ok && tries < MAXR) begin
                exp_q.push_back(rom[a]);
                tries++;
                nk = nack_all ? 1'b1 : (np.size() > 0 ? np.pop_front() : 1'b0);
                ok = !nk;
            end
            if (!ok) begin exp_err = 1; break; end
            if (wc < 255) wc++;
            if (a == 255) exp_done = 1;
        end
        exp_wc = 8'(wc);
    endtask

    task automatic load_basic_rom();
        for (int i = 0; i < 256; i++) rom[i] = 16'hFFFF;
        rom[0] = 16'h1280; rom[1] = 16'hFFF0; rom[2] = 16'h1214; rom[3] = 16'hFFFF;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_end(input int budget, output bit ok);
        ok = 0;
        repeat (2) @(negedge clk);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            #2;
            if (busy === 1'b0 && (config_done === 1'b1 || config_error === 1'b1) && !pend) begin
                ok = 1;
                break;
            end
        end
    endtask

    task automatic wait_log(input int n, input int budget, output bit ok);
        ok = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            #2;
            if (log_q.size() >= n) begin ok = 1; break; end
        end
    endtask

    function automatic int list_mism();
        int m = 0;
        if (log_q.size() != exp_q.size()) m++;
        foreach (exp_q[i]) if (i < log_q.size() && log_q[i] !== exp_q[i]) m++;
        return m;
    endfunction

    task automatic test_reset();
        load_basic_rom();
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        #2;
        total++;
        if ({rom_addr, sccb_start, sccb_reg, sccb_data} !== 25'd0) begin
            bad++;
            $display("FAIL reset_datapath: got addr=%h start=%b reg=%h data=%h want all zero",
                     rom_addr, sccb_start, sccb_reg, sccb_data);
        end
        total++;
        if ({busy, config_done, config_error, write_count} !== 11'd0) begin
            bad++;
            $display("FAIL reset_status: got busy=%b done=%b err=%b wc=%0d want 0/0/0/0",
                     busy, config_done, config_error, write_count);
        end
        log_q.delete(); log_t.delete(); done_t.delete();
        reset_n = 1'b1;
        @(negedge clk);
        #2;
        total++;
        if (busy !== 1'b1) begin
            bad++;
            $display("FAIL auto_start: got busy=%b want 1 one cycle after reset release", busy);
        end
    endtask

    task automatic test_basic();
        bit ok;
        int gap;
        ref_plan.delete();
        ref_model();
        wait_end(5000, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL basic_timeout: busy=%b want finished run", busy); end
        total++;
        if (list_mism() != 0) begin
            bad++;
            $display("FAIL basic_writes: got %0d writes want %0d (12/80 then 12/14)", log_q.size(), exp_q.size());
        end
        total++;
        if ({config_done, config_error, busy, write_count} !== {exp_done, exp_err, 1'b0, exp_wc}) begin
            bad++;
            $display("FAIL basic_status: got done=%b err=%b busy=%b wc=%0d want 1/0/0/%0d",
                     config_done, config_error, busy, write_count, exp_wc);
        end
        // done-sample edge + ADVANCE,FETCH x2,DECODE before and after the DLY cycles of DELAY
        gap = (log_t.size() > 1 && done_t.size() > 0) ? log_t[1] - done_t[0] : -1;
        total++;
        if (gap != DLY + 9) begin
            bad++;
            $display("FAIL basic_delay_gap: got %0d cycles want %0d", gap, DLY + 9);
        end
    endtask

    task automatic test_nack_retry();
        bit ok;
        lat = $urandom_range(2, 10);
        nack_plan = '{1'b1, 1'b1};
        ref_plan = '{1'b1, 1'b1};
        ref_model();
        log_q.delete();
        pulse_start();
        wait_end(5000, ok);
        total++;
        if (!ok || list_mism() != 0) begin
            bad++;
            $display("FAIL nack_retry_writes: got %0d starts want %0d (12/80 x3 then 12/14)", log_q.size(), exp_q.size());
        end
        total++;
        if ({config_done, config_error, write_count} !== {1'b1, 1'b0, 8'd2}) begin
            bad++;
            $display("FAIL nack_retry_status: got done=%b err=%b wc=%0d want 1/0/2",
                     config_done, config_error, write_count);
        end
    endtask

    task automatic test_nack_error();
        bit ok;
        nack_all = 1;
        ref_plan.delete();
        ref_model();
        log_q.delete();
        pulse_start();
        wait_end(5000, ok);
        repeat (40) @(negedge clk);
        #2;
        total++;
        if (!ok || list_mism() != 0 || log_q.size() != MAXR) begin
            bad++;
            $display("FAIL nack_error_starts: got %0d starts want %0d", log_q.size(), MAXR);
        end
        total++;
        if ({config_done, config_error, rom_addr, write_count, busy} !== {1'b0, 1'b1, 8'd0, 8'd0, 1'b0}) begin
            bad++;
            $display("FAIL nack_error_status: got done=%b err=%b addr=%0d wc=%0d busy=%b want 0/1/0/0/0",
                     config_done, config_error, rom_addr, write_count, busy);
        end
        nack_all = 0;
    endtask

    task automatic test_ready_stall();
        bit ok;
        int rel;
        lat = $urandom_range(3, 12);
        ref_plan.delete();
        ref_model();
        ready_block = 1;
        log_q.delete(); log_t.delete();
        pulse_start();
        repeat (50) @(negedge clk);
        #3;
        total++;
        if (log_q.size() != 0 || busy !== 1'b1) begin
            bad++;
            $display("FAIL stall_no_start: got %0d starts busy=%b want 0 starts busy=1", log_q.size(), busy);
        end
        ready_block = 0;
        rel = cyc + 1;
        wait_log(1, 20, ok);
        total++;
        if (!ok || log_t[0] != rel) begin
            bad++;
            $display("FAIL stall_first_ready: got start at cycle %0d want %0d", ok ? log_t[0] : -1, rel);
        end
        wait_end(5000, ok);
        total++;
        if (!ok || list_mism() != 0 || write_count !== exp_wc) begin
            bad++;
            $display("FAIL stall_run: got %0d writes wc=%0d want %0d wc=%0d", log_q.size(), write_count, exp_q.size(), exp_wc);
        end
    endtask

    task automatic test_reset_abort();
        bit ok;
        lat = 20;
        ref_plan.delete();
        ref_model();
        log_q.delete();
        pulse_start();
        wait_log(1, 100, ok);
        repeat (5) @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        #2;
        total++;
        if ({rom_addr, sccb_start, sccb_reg, sccb_data, busy, config_done, config_error, write_count} !== 36'd0) begin
            bad++;
            $display("FAIL abort_reset_values: got addr=%h start=%b reg=%h data=%h busy=%b done=%b err=%b wc=%0d want all zero",
                     rom_addr, sccb_start, sccb_reg, sccb_data, busy, config_done, config_error, write_count);
        end
        log_q.delete();
        reset_n = 1'b1;
        wait_end(5000, ok);
        total++;
        if (!ok || list_mism() != 0 || {config_done, config_error, write_count} !== {1'b1, 1'b0, 8'd2}) begin
            bad++;
            $display("FAIL abort_restart: got %0d writes done=%b wc=%0d want %0d writes done=1 wc=2",
                     log_q.size(), config_done, write_count, exp_q.size());
        end
    endtask

    task automatic test_random();
        bit ok;
        int n;
        for (int it = 0; it < 5; it++) begin
            for (int i = 0; i < 256; i++) rom[i] = 16'hFFFF;
            n = $urandom_range(1, 10);
            for (int i = 0; i < n; i++)
                rom[i] = ($urandom_range(0, 4) == 0) ? 16'hFFF0 : {8'($urandom_range(0, 254)), 8'($urandom)};
            ref_plan.delete();
            for (int i = 0; i < 30; i++) ref_plan.push_back($urandom_range(0, 3) == 0);
            nack_plan = ref_plan;
            lat = $urandom_range(1, 6);
            ref_model();
            log_q.delete();
            pulse_start();
            wait_end(5000, ok);
            total++;
            if (!ok || list_mism() != 0) begin
                bad++;
                $display("FAIL random%0d_writes: got %0d starts want %0d", it, log_q.size(), exp_q.size());
            end
            total++;
            if ({config_done, config_error, write_count, rom_addr} !== {exp_done, exp_err, exp_wc, exp_addr}) begin
                bad++;
                $display("FAIL random%0d_status: got done=%b err=%b wc=%0d addr=%0d want %b/%b/%0d/%0d", it,
                         config_done, config_error, write_count, rom_addr, exp_done, exp_err, exp_wc, exp_addr);
            end
        end
        nack_plan.delete();
    endtask

    task automatic test_full_rom();
        bit ok;
        for (int i = 0; i < 256; i++) rom[i] = {8'($urandom_range(0, 254)), 8'($urandom)};
        lat = 2;
        ref_plan.delete();
        ref_model();
        log_q.delete();
        pulse_start();
        wait_log(100, 5000, ok);
        pulse_start();
        wait_end(20000, ok);
        total++;
        if (!ok || list_mism() != 0 || log_q.size() != 256) begin
            bad++;
            $display("FAIL full_writes: got %0d starts want 256 in table order", log_q.size());
        end
        total++;
        if ({config_done, config_error, write_count, rom_addr} !== {1'b1, 1'b0, 8'd255, 8'd255}) begin
            bad++;
            $display("FAIL full_status: got done=%b err=%b wc=%0d addr=%0d want 1/0/255/255",
                     config_done, config_error, write_count, rom_addr);
        end
        log_q.delete();
        pulse_start();
        wait_end(20000, ok);
        total++;
        if (!ok || list_mism() != 0 || write_count !== 8'd255) begin
            bad++;
            $display("FAIL full_rerun: got %0d starts wc=%0d want 256 from address 0 wc=255", log_q.size(), write_count);
        end
    endtask

    task automatic test_handshake();
        total++;
        if (consec_bad != 0) begin
            bad++;
            $display("FAIL start_consecutive: got %0d back-to-back start cycles want 0", consec_bad);
        end
        total++;
        if (stab_bad != 0) begin
            bad++;
            $display("FAIL reg_data_stable: got %0d changes during a write want 0", stab_bad);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_nack_retry();
        test_nack_error();
        test_ready_stall();
        load_basic_rom();
        test_reset_abort();
        test_random();
        test_full_rom();
        test_handshake();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
